popcount_compressor: RTL and testbench

Pipelined, parametrised N-input bit counter for the multiplier's partial-product reduction and its self-test logic. Each accepted beat of N bits is reduced to its population count: 4:3 counters first, then a registered adder tree. An optional accumulate mode sums counts across beats into a wide accumulator with a sticky overflow flag. Valid/ready handshakes on both sides let the block sit between the partial-product generator and the final adder with full backpressure.

---
 rtl/popcount_compressor.sv | 154 +++++++++++++++
 tb/tb_popcount_compressor.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_compressor.sv
// popcount_compressor
//   Pipelined N-bit population counter with an optional accumulator.
//   S1 registers one 4:3-counter result per nibble, S2 registers the summed
//   total, and S3 is the output register. The whole pipe advances together
//   whenever the output register is empty or being consumed.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake for x and mode
//   x                   N bits to count
//   mode                0: count only, 1: also add the count into acc
//   acc_clr             clear acc and acc_ovf (clear happens before an add
//                       on the same edge)
//   out_valid/out_ready output handshake for count
//   count               popcount of the beat held in the output register
//   acc, acc_ovf        accumulator and its sticky overflow flag
module popcount_compressor #(
    parameter int unsigned N     = 16,
    parameter int unsigned ACC_W = 16,
    localparam int unsigned CW   = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     x,
    input  logic             mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf
);

    localparam int unsigned NG = N / 4;

    // 4:3 counter, result packed as {c2, c1, s} so it reads as a binary 0..4.
    // Two weight-2 terms are only both set when all four inputs are set,
    // which is exactly the c2 case.
    function automatic logic [2:0] cnt43(input logic [3:0] b);
        logic s_lo, c_lo, s_hi, c_hi, c_mid;
        s_lo  = b[0] ^ b[1];
        c_lo  = b[0] & b[1];
        s_hi  = b[2] ^ b[3];
        c_hi  = b[2] & b[3];
        c_mid = s_lo & s_hi;
        return {c_lo & c_hi, c_lo ^ c_hi ^ c_mid, s_lo ^ s_hi};
    endfunction

    logic                  advance;
    logic                  enter_acc;

    logic                  s1_valid_q, s1_valid_d;
    logic [NG-1:0][2:0]    s1_grp_q, s1_grp_d;
    logic                  s1_mode_q, s1_mode_d;

    logic                  s2_valid_q, s2_valid_d;
    logic [CW-1:0]         s2_sum_q, s2_sum_d;
    logic                  s2_mode_q, s2_mode_d;

    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         count_q, count_d;

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  acc_ovf_q, acc_ovf_d;

    logic [NG-1:0][2:0]    grp_val;
    logic [CW-1:0]         grp_total;
    logic [ACC_W-1:0]      acc_base;
    logic                  ovf_base;
    logic [ACC_W:0]        acc_sum;

    always_comb begin
        grp_val = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            grp_val[g] = cnt43(x[4*g +: 4]);
        end
    end

    always_comb begin
        grp_total = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            grp_total = grp_total + CW'(s1_grp_q[g]);
        end
    end

    always_comb begin
        advance     = ~out_valid_q | out_ready;

        s1_valid_d  = s1_valid_q;
        s1_grp_d    = s1_grp_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        s2_sum_d    = s2_sum_q;
        s2_mode_d   = s2_mode_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;

        // Bubbles shift along with real beats; nothing is compressed.
        if (advance) begin
            s1_valid_d  = in_valid;
            s1_grp_d    = grp_val;
            s1_mode_d   = mode;
            s2_valid_d  = s1_valid_q;
            s2_sum_d    = grp_total;
            s2_mode_d   = s1_mode_q;
            out_valid_d = s2_valid_q;
            count_d     = s2_sum_q;
        end

        // The add uses the S2 total on the edge that moves it into S3, so
        // acc is updated in the same cycle that beat's count is presented.
        enter_acc = advance & s2_valid_q & s2_mode_q;
        acc_base  = acc_clr ? '0   : acc_q;
        ovf_base  = acc_clr ? 1'b0 : acc_ovf_q;
        acc_sum   = {1'b0, acc_base} + {{(ACC_W + 1 - CW){1'b0}}, s2_sum_q};
        acc_d     = enter_acc ? acc_sum[ACC_W-1:0] : acc_base;
        acc_ovf_d = ovf_base | (enter_acc & acc_sum[ACC_W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_grp_q    <= '0;
            s1_mode_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sum_q    <= '0;
            s2_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_grp_q    <= s1_grp_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_sum_q    <= s2_sum_d;
            s2_mode_q   <= s2_mode_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign count     = count_q;
    assign acc       = acc_q;
    assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_popcount_compressor.sv
// Bench for popcount_compressor: three instances (N=4, N=16, N=64) share
// all control inputs and the low bits of one data word, so they run in
// lockstep. A reference model tracks accepted beats in a queue and the
// expected accumulators with plain integer arithmetic.
module tb_popcount_compressor;

    logic        clk = 1'b0;
    logic        rst, in_valid, mode, acc_clr, out_ready;
    logic [63:0] xw;

    logic        ir4, ir16, ir64, ov4, ov16, ov64, of4, of16, of64;
    logic [2:0]  c4;
    logic [4:0]  c16;
    logic [6:0]  c64;
    logic [3:0]  a4;
    logic [4:0]  a16;
    logic [9:0]  a64;

    always #5 clk = ~clk;

    popcount_compressor #(.N(4), .ACC_W(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .x(xw[3:0]),
        .mode(mode), .acc_clr(acc_clr), .out_valid(ov4), .out_ready(out_ready),
        .count(c4), .acc(a4), .acc_ovf(of4));

    popcount_compressor #(.N(16), .ACC_W(5)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .x(xw[15:0]),
        .mode(mode), .acc_clr(acc_clr), .out_valid(ov16), .out_ready(out_ready),
        .count(c16), .acc(a16), .acc_ovf(of16));

    popcount_compressor #(.N(64), .ACC_W(10)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .x(xw),
        .mode(mode), .acc_clr(acc_clr), .out_valid(ov64), .out_ready(out_ready),
        .count(c64), .acc(a64), .acc_ovf(of64));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic            m;
        logic [2:0][6:0] c;
    } beat_t;

    beat_t q[$];
    beat_t cur;
    beat_t e_beat;
    int    hs_log[$];
    int    acc_m[3];
    int    ovf_m[3];
    int    accw[3] = '{4, 5, 10};
    bit    started = 0;
    bit    e_rst, e_clr, e_acc, e_ov, e_hs;

    // What happened at this edge (pre-edge values).
    always @(posedge clk) begin
        e_rst    = rst;
        e_clr    = acc_clr;
        e_acc    = in_valid & ir16;
        e_ov     = ov16;
        e_hs     = ov16 & out_ready;
        e_beat.m    = mode;
        e_beat.c[0] = 7'($countones(xw[3:0]));
        e_beat.c[1] = 7'($countones(xw[15:0]));
        e_beat.c[2] = 7'($countones(xw));
        if (started && !rst && ov16 && out_ready) hs_log.push_back(int'(c16));
        if (rst) started = 1;
    end

    always @(negedge clk) begin
        bit newres;
        int s;
        if (started) begin
            if (e_rst) begin
                q.delete();
                for (int d = 0; d < 3; d++) begin acc_m[d] = 0; ovf_m[d] = 0; end
                chk("rst_out_valid", ov16, 0);
                chk("rst_count", c16, 0);
            end else begin
                if (e_clr) for (int d = 0; d < 3; d++) begin acc_m[d] = 0; ovf_m[d] = 0; end
                newres = ov16 && (!e_ov || e_hs);
                if (newres) begin
                    chk("result_has_pending_beat", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        if (cur.m) begin
                            for (int d = 0; d < 3; d++) begin
                                s = acc_m[d] + int'(cur.c[d]);
                                if (s >= (1 << accw[d])) ovf_m[d] = 1;
                                acc_m[d] = s % (1 << accw[d]);
                            end
                        end
                    end
                end
                if (e_acc) q.push_back(e_beat);
                if (ov16) begin
                    chk("model_count_n4", c4, cur.c[0]);
                    chk("model_count_n16", c16, cur.c[1]);
                    chk("model_count_n64", c64, cur.c[2]);
                end
            end
            chk("model_acc_n4", a4, acc_m[0]);
            chk("model_acc_n16", a16, acc_m[1]);
            chk("model_acc_n64", a64, acc_m[2]);
            chk("model_ovf_n4", of4, ovf_m[0]);
            chk("model_ovf_n16", of16, ovf_m[1]);
            chk("model_ovf_n64", of64, ovf_m[2]);
            chk("lockstep_valid_n4", ov4, ov16);
            chk("lockstep_valid_n64", ov64, ov16);
            chk("in_ready_rule", ir16, !ov16 || out_ready);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_wait(input string name);
        int t = 0;
        bit ok = 0;
        while (!ok && t < 20) begin
            @(posedge clk);
            ok = ir16;
            #1;
            t++;
        end
        chk(name, ok, 1);
    endtask

    task automatic send(input logic [63:0] v, input logic m);
        int t = 0;
        tick();
        xw = v; mode = m; in_valid = 1'b1;
        accept_wait("send_accept");
        in_valid = 1'b0;
        @(negedge clk);
        while (!ov16 && t < 10) begin @(negedge clk); t++; end
        chk("send_result_valid", ov16, 1);
    endtask

    typedef struct {
        logic [15:0] x;
        logic        m;
        int          exp;
    } vec_t;

    vec_t vt[7];
    logic [4:0] held;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{16'h0000, 1'b0, 0};
        vt[1] = '{16'h0001, 1'b0, 1};
        vt[2] = '{16'h8421, 1'b0, 4};
        vt[3] = '{16'hF0F0, 1'b0, 8};
        vt[4] = '{16'hFFFF, 1'b0, 16};
        vt[5] = '{16'hAAAA, 1'b0, 8};
        vt[6] = '{16'h7FFE, 1'b0, 14};

        rst = 1; in_valid = 0; mode = 0; acc_clr = 0; out_ready = 1; xw = '0;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        chk("reset_out_valid", ov16, 0);
        chk("reset_count", c16, 0);
        chk("reset_acc", a16, 0);
        chk("reset_ovf", of16, 0);
        chk("reset_in_ready", ir16, 1);

        // single all-ones beat: latency of two edges after acceptance
        tick();
        xw = 64'hFFFF; mode = 0; in_valid = 1;
        tick();
        in_valid = 0;
        @(negedge clk); chk("latency_edge_n", ov16, 0);
        @(negedge clk); chk("latency_edge_n1", ov16, 0);
        @(negedge clk);
        chk("latency_edge_n2_valid", ov16, 1);
        chk("ffff_count", c16, 16);
        chk("ffff_acc", a16, 0);

        // back-to-back table stream, no gaps on the output
        tick();
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    xw = {48'd0, vt[i].x}; mode = vt[i].m; in_valid = 1;
                    tick();
                end
                in_valid = 0;
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!ov16 && t < 10) begin @(negedge clk); t++; end
                for (int k = 0; k < 7; k++) begin
                    chk("stream_valid", ov16, 1);
                    chk("stream_count", c16, vt[k].exp);
                    if (k < 6) @(negedge clk);
                end
            end
        join
        repeat (3) tick();

        // stall for five edges with in_valid held high
        hs_log.delete();
        fork
            begin
                for (int k = 1; k <= 8; k++) begin
                    xw = (64'd1 << k) - 64'd1; mode = 0; in_valid = 1;
                    accept_wait("stall_accept");
                end
                in_valid = 0;
            end
            begin
                repeat (4) tick();
                out_ready = 0;
                @(negedge clk);
                held = c16;
                for (int j = 0; j < 5; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("stall_in_ready", ir16, 0);
                    chk("stall_out_valid", ov16, 1);
                    chk("stall_count_stable", c16, held);
                    tick();
                end
                out_ready = 1;
            end
        join
        in_valid = 0;
        repeat (8) tick();
        chk("stall_beats_out", hs_log.size(), 8);
        for (int k = 0; k < hs_log.size() && k < 8; k++) chk("stall_order", hs_log[k], k + 1);

        // accumulate with 5-bit wrap
        tick(); acc_clr = 1; tick(); acc_clr = 0;
        @(negedge clk);
        chk("acc_clear0", a16, 0);
        send(64'hFFFF, 1); chk("acc_16", a16, 16); chk("ovf_16", of16, 0);
        send(64'h7FFF, 1); chk("acc_31", a16, 31); chk("ovf_31", of16, 0);
        send(64'h0003, 1); chk("acc_wrap1", a16, 1); chk("ovf_wrap", of16, 1);
        send(64'h00F0, 0); chk("acc_mode0_hold", a16, 1); chk("ovf_sticky", of16, 1);
        tick(); acc_clr = 1; tick(); acc_clr = 0;
        @(negedge clk);
        chk("acc_clr_acc", a16, 0); chk("acc_clr_ovf", of16, 0);

        // clear on the same edge a mode=1 beat enters the output stage
        send(64'hFFFF, 1);
        send(64'hFFFF, 1);
        send(64'h01FF, 1);
        chk("pre_clr_acc", a16, 9); chk("pre_clr_ovf", of16, 1);
        tick();
        xw = 64'h007F; mode = 1; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        acc_clr = 1;
        tick();
        acc_clr = 0;
        @(negedge clk);
        chk("clr_add_valid", ov16, 1);
        chk("clr_add_count", c16, 7);
        chk("clr_add_acc", a16, 7);
        chk("clr_add_ovf", of16, 0);

        // reset with three beats in flight
        tick();
        out_ready = 0; mode = 1; in_valid = 1; xw = 64'hFFFF;
        tick(); tick(); tick();
        in_valid = 0;
        @(negedge clk);
        chk("inflight_valid", ov16, 1);
        chk("inflight_acc", a16, 23);
        tick(); rst = 1; tick(); rst = 0; out_ready = 1;
        @(negedge clk);
        chk("rst_flight_valid", ov16, 0);
        chk("rst_flight_acc", a16, 0);
        chk("rst_flight_ovf", of16, 0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("no_stale_result", ov16, 0);
        end

        // randomized run, checked by the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            mode      = 1'($urandom);
            acc_clr   = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            xw        = {$urandom, $urandom};
            case ($urandom_range(0, 15))
                0: xw = '1;
                1: xw = '0;
                default: ;
            endcase
        end
        tick();
        rst = 0; in_valid = 0; acc_clr = 0; out_ready = 1;
        repeat (6) tick();
        @(negedge clk);
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_out_valid", ov16, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
